// File: rtl/bus_initiator_if.sv
//------------------------------------------------------------------------------
// bus_initiator_if : command, response and peripheral-bus signals of bus_initiator
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface bus_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        bus_sel;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output bus_sel, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rdata
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  bus_sel, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rdata
  );
endinterface

`default_nettype wire

// File: rtl/bus_initiator.sv
//------------------------------------------------------------------------------
// bus_initiator : single-outstanding command-to-peripheral bridge with timeout
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             resetn,
  bus_initiator_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Wait-counter value at which the final allowed ACCESS cycle ends.
  localparam logic [7:0] c_timeout_last =
    (TIMEOUT_CYCLES == 0) ? 8'd0 : 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 8'd0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_wstrb_q <= 4'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          bus_we_d    = bus.cmd_we;
          bus_addr_d  = bus.cmd_addr;
          bus_wdata_d = bus.cmd_wdata;
          bus_wstrb_d = bus.cmd_wstrb;
          wait_cnt_d  = 8'd0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        // A ready on the timeout edge still counts as a normal completion.
        if (bus.bus_ready) begin
          rsp_rdata_d = bus_we_q ? 32'd0 : bus.bus_rdata;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_q == c_timeout_last)) begin
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = resetn && (state_q == IDLE);
  assign bus.bus_sel   = (state_q == ACCESS);
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_wstrb = bus_wstrb_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_initiator.sv
//------------------------------------------------------------------------------
// tb_bus_initiator : two initiators (timeout 8 and 255) on shared stimulus vs. a transaction model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_initiator;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_we, rsp_ready, bus_ready;
  logic [31:0] cmd_addr, cmd_wdata, bus_rdata;
  logic [3:0]  cmd_wstrb;

  bus_initiator_if ifa ();
  bus_initiator_if ifb ();

  assign ifa.cmd_valid = cmd_valid;  assign ifb.cmd_valid = cmd_valid;
  assign ifa.cmd_we    = cmd_we;     assign ifb.cmd_we    = cmd_we;
  assign ifa.cmd_addr  = cmd_addr;   assign ifb.cmd_addr  = cmd_addr;
  assign ifa.cmd_wdata = cmd_wdata;  assign ifb.cmd_wdata = cmd_wdata;
  assign ifa.cmd_wstrb = cmd_wstrb;  assign ifb.cmd_wstrb = cmd_wstrb;
  assign ifa.rsp_ready = rsp_ready;  assign ifb.rsp_ready = rsp_ready;
  assign ifa.bus_ready = bus_ready;  assign ifb.bus_ready = bus_ready;
  assign ifa.bus_rdata = bus_rdata;  assign ifb.bus_rdata = bus_rdata;

  bus_initiator #(.TIMEOUT_CYCLES(8)) dut8 (.clk(clk), .resetn(resetn), .bus(ifa.master));
  bus_initiator #(.TIMEOUT_CYCLES(255)) dut255 (.clk(clk), .resetn(resetn), .bus(ifb.master));

  logic [1:0]  o_cmd_ready, o_sel, o_we, o_rv, o_err;
  logic [31:0] o_addr [2];
  logic [31:0] o_wdata[2];
  logic [31:0] o_rdata[2];
  logic [3:0]  o_wstrb[2];
  assign o_cmd_ready = {ifb.cmd_ready, ifa.cmd_ready};
  assign o_sel       = {ifb.bus_sel,   ifa.bus_sel};
  assign o_we        = {ifb.bus_we,    ifa.bus_we};
  assign o_rv        = {ifb.rsp_valid, ifa.rsp_valid};
  assign o_err       = {ifb.rsp_err,   ifa.rsp_err};
  assign o_addr[0]  = ifa.bus_addr;   assign o_addr[1]  = ifb.bus_addr;
  assign o_wdata[0] = ifa.bus_wdata;  assign o_wdata[1] = ifb.bus_wdata;
  assign o_rdata[0] = ifa.rsp_rdata;  assign o_rdata[1] = ifb.rsp_rdata;
  assign o_wstrb[0] = ifa.bus_wstrb;  assign o_wstrb[1] = ifb.bus_wstrb;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h", name, k, got, exp);
    end
  endtask

  // Transaction-level model: phase 0=waiting for command, 1=request on bus, 2=holding response.
  // sel_cycles counts how many cycles the request has been presented so far.
  int          tmo[2];
  int          m_phase[2];
  int          m_sel_cycles[2];
  logic        m_we[2];
  logic [31:0] m_addr[2], m_wdata[2], m_rdata[2];
  logic [3:0]  m_wstrb[2];
  logic        m_err[2];
  initial begin
    tmo[0] = 8;
    tmo[1] = 255;
  end

  always @(posedge clk or negedge resetn) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        m_phase[k] <= 0; m_sel_cycles[k] <= 0; m_we[k] <= 1'b0;
        m_addr[k] <= '0; m_wdata[k] <= '0; m_wstrb[k] <= '0;
        m_rdata[k] <= '0; m_err[k] <= 1'b0;
      end else if (m_phase[k] == 0) begin
        if (cmd_valid) begin
          m_phase[k] <= 1; m_sel_cycles[k] <= 1; m_we[k] <= cmd_we;
          m_addr[k] <= cmd_addr; m_wdata[k] <= cmd_wdata; m_wstrb[k] <= cmd_wstrb;
        end
      end else if (m_phase[k] == 1) begin
        if (bus_ready) begin
          m_phase[k] <= 2; m_err[k] <= 1'b0;
          m_rdata[k] <= m_we[k] ? 32'd0 : bus_rdata;
        end else if (m_sel_cycles[k] == tmo[k]) begin
          m_phase[k] <= 2; m_err[k] <= 1'b1; m_rdata[k] <= 32'd0;
        end else begin
          m_sel_cycles[k] <= m_sel_cycles[k] + 1;
        end
      end else if (rsp_ready) begin
        m_phase[k] <= 0;
      end
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check("cmd_ready", k, 32'(o_cmd_ready[k]), 32'(resetn && m_phase[k] == 0));
        check("bus_sel",   k, 32'(o_sel[k]),       32'(m_phase[k] == 1));
        check("rsp_valid", k, 32'(o_rv[k]),        32'(m_phase[k] == 2));
        if (m_phase[k] == 1) begin
          check("bus_we",    k, 32'(o_we[k]),    32'(m_we[k]));
          check("bus_addr",  k, o_addr[k],       m_addr[k]);
          check("bus_wdata", k, o_wdata[k],      m_wdata[k]);
          check("bus_wstrb", k, 32'(o_wstrb[k]), 32'(m_wstrb[k]));
        end
        if (m_phase[k] == 2) begin
          check("rsp_rdata", k, o_rdata[k],      m_rdata[k]);
          check("rsp_err",   k, 32'(o_err[k]),   32'(m_err[k]));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] strb);
    tick();
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Starts in request cycle 1; ready is presented during request cycle rdy_at (0 = never).
  task automatic run_access(input int n, input int rdy_at, input logic [31:0] rd, output int c0, output int c1);
    c0 = 0; c1 = 0;
    for (int i = 1; i <= n; i++) begin
      if (o_sel[0]) c0++;
      if (o_sel[1]) c1++;
      bus_ready = (i == rdy_at);
      bus_rdata = rd;
      tick();
    end
    bus_ready = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  int c0, c1, pct;

  initial begin
    cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0; bus_ready = 0; bus_rdata = 0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      check("rst_cmd_ready", k, 32'(o_cmd_ready[k]), 32'd0);
      check("rst_bus_sel",   k, 32'(o_sel[k]),       32'd0);
      check("rst_bus_addr",  k, o_addr[k],           32'd0);
      check("rst_rsp_valid", k, 32'(o_rv[k]),        32'd0);
    end
    resetn = 1'b1;

    // Write with ready after 15 wait cycles: dut255 completes, dut8 times out after 8.
    issue(1'b1, 32'h8000_0000, 32'h0000_002A, 4'hF);
    run_access(16, 16, 32'hDEAD_BEEF, c0, c1);
    check("tmo_sel_cycles", 0, 32'(c0), 32'd8);
    check("wr_sel_cycles",  1, 32'(c1), 32'd16);
    check("tmo_err",   0, 32'(o_err[0]), 32'd1);
    check("tmo_rdata", 0, o_rdata[0],    32'd0);
    check("wr_err",    1, 32'(o_err[1]), 32'd0);
    check("wr_rdata",  1, o_rdata[1],    32'd0);
    check("wr_wdata",  1, o_wdata[1],    32'h2A);
    finish_rsp();

    // Read with ready in the third request cycle.
    issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
    run_access(3, 3, 32'h0000_003F, c0, c1);
    for (int k = 0; k < 2; k++) begin
      check("rd_sel_after_ready", k, 32'(o_sel[k]), 32'd0);
      check("rd_rdata", k, o_rdata[k], 32'h3F);
      check("rd_err",   k, 32'(o_err[k]), 32'd0);
    end
    finish_rsp();

    // Ready on the 8th cycle: coincides with dut8's timeout edge, completion wins.
    issue(1'b0, 32'h0000_2000, 32'h0, 4'h0);
    run_access(8, 8, 32'hA5A5_1234, c0, c1);
    for (int k = 0; k < 2; k++) begin
      check("edge_rdata", k, o_rdata[k], 32'hA5A5_1234);
      check("edge_err",   k, 32'(o_err[k]), 32'd0);
    end

    // Response backpressure with a new command held pending.
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h0000_3000; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'h3;
    for (int j = 0; j < 5; j++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        check("bp_cmd_ready", k, 32'(o_cmd_ready[k]), 32'd0);
        check("bp_bus_sel",   k, 32'(o_sel[k]),       32'd0);
        check("bp_rdata",     k, o_rdata[k],          32'hA5A5_1234);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_accept_ready", 0, 32'(o_cmd_ready[0]), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("bp_next_sel", 0, 32'(o_sel[0]), 32'd1);
    run_access(2, 2, 32'h0, c0, c1);
    finish_rsp();

    // Asynchronous reset in the middle of a request.
    issue(1'b0, 32'h0000_4000, 32'h0, 4'h0);
    run_access(3, 0, 32'h0, c0, c1);
    #1 resetn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("arst_bus_sel",   k, 32'(o_sel[k]), 32'd0);
      check("arst_rsp_valid", k, 32'(o_rv[k]),  32'd0);
    end
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0000_5000;
    tick();
    resetn = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("arst_first_sel", 1, 32'(o_sel[1]), 32'd1);
    run_access(2, 2, 32'h0BAD_F00D, c0, c1);
    check("arst_rdata", 1, o_rdata[1], 32'h0BAD_F00D);
    finish_rsp();

    // Randomized traffic with varying slave latency and occasional resets.
    pct = 20;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) pct = 3 + int'($urandom_range(0, 3)) * 25;
      resetn    = ($urandom_range(0, 599) != 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_we    = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_wstrb = 4'($urandom);
      rsp_ready = 1'($urandom);
      bus_ready = (int'($urandom_range(0, 99)) < pct);
      bus_rdata = $urandom;
      tick();
    end
    resetn = 1'b1;
    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
